rosetta_loop_sequencer: RTL and testbench

- Loop/address sequencer for the ROSETTA core. It sits between the instruction decoder and the core controller.
- On each decoded compute instruction it runs the nested MVMA loop counters (k inner, i middle, j outer) or the element loop (EMAC/ENOF).
- It produces the k_end/i_end/j_end/j_end_reg/e_end flags that the controller consumes, and drives the AM/WM/BM read/write addresses.
- It advances only when the controller is not holding the pipeline.

---
 rtl/rosetta_loop_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_rosetta_loop_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rosetta_loop_sequencer.sv
// Loop/address sequencer: runs nested MVMA k/i/j counters or a flat element loop,
// emits loop-end flags and AM/WM/BM addresses; all loop state freezes while hold is high.
module rosetta_loop_sequencer #(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [CNT_W-1:0]  k_last,
  input  logic [CNT_W-1:0]  i_last,
  input  logic [CNT_W-1:0]  j_last,
  input  logic [CNT_W-1:0]  e_last,
  input  logic [ADDR_W-1:0] src0_base,
  input  logic [ADDR_W-1:0] src1_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] wm_base,
  input  logic [ADDR_W-1:0] bm_base,
  input  logic              hold,
  output logic              k_end,
  output logic              i_end,
  output logic              j_end,
  output logic              j_end_reg,
  output logic              e_end,
  output logic [ADDR_W-1:0] am_src0_addr,
  output logic [ADDR_W-1:0] am_src1_addr,
  output logic [ADDR_W-1:0] am_dst_addr,
  output logic [ADDR_W-1:0] wm_addr,
  output logic [ADDR_W-1:0] bm_addr,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MVMA = 2'd1,
    ST_ELEM = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]  k, i, j, e;
  logic [CNT_W-1:0]  k_nxt, i_nxt, j_nxt, e_nxt;
  logic [CNT_W-1:0]  k_lim, i_lim, j_lim, e_lim;
  logic [ADDR_W-1:0] src0_b, src1_b, dst_b, bm_b;
  logic              fin_mvma;

  logic launch;
  logic adv;
  logic k_wrap, i_wrap, j_wrap, e_wrap;

  assign launch = (state == ST_IDLE) && start;
  assign adv    = ((state == ST_MVMA) || (state == ST_ELEM)) && !hold;

  // Wrap conditions chain inner-to-outer so a j wrap implies i and k wraps.
  assign k_wrap = (k == k_lim);
  assign i_wrap = k_wrap && (i == i_lim);
  assign j_wrap = i_wrap && (j == j_lim);
  assign e_wrap = (e == e_lim);

  // Flags decode the current counters, so they remain valid across stalls.
  assign k_end = (state == ST_MVMA) && k_wrap;
  assign i_end = (state == ST_MVMA) && i_wrap;
  assign e_end = (state == ST_ELEM) && e_wrap;
  assign j_end = (state == ST_FIN) && fin_mvma;
  assign busy  = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = mode ? ST_ELEM : ST_MVMA;
        end
      end
      ST_MVMA: begin
        if (adv && j_wrap) begin
          state_nxt = ST_FIN;
        end
      end
      ST_ELEM: begin
        if (adv && e_wrap) begin
          state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    k_nxt = k_wrap ? '0 : k + CNT_W'(1);
    i_nxt = i;
    j_nxt = j;
    if (k_wrap) begin
      i_nxt = i_wrap ? '0 : i + CNT_W'(1);
    end
    if (i_wrap) begin
      j_nxt = j_wrap ? '0 : j + CNT_W'(1);
    end
    e_nxt = e_wrap ? '0 : e + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= '0;
      i        <= '0;
      j        <= '0;
      e        <= '0;
      k_lim    <= '0;
      i_lim    <= '0;
      j_lim    <= '0;
      e_lim    <= '0;
      src0_b   <= '0;
      src1_b   <= '0;
      dst_b    <= '0;
      bm_b     <= '0;
      fin_mvma <= 1'b0;
    end else if (launch) begin
      k        <= '0;
      i        <= '0;
      j        <= '0;
      e        <= '0;
      k_lim    <= k_last;
      i_lim    <= i_last;
      j_lim    <= j_last;
      e_lim    <= e_last;
      src0_b   <= src0_base;
      src1_b   <= src1_base;
      dst_b    <= dst_base;
      bm_b     <= bm_base;
      fin_mvma <= !mode;
    end else if (adv) begin
      if (state == ST_MVMA) begin
        k <= k_nxt;
        i <= i_nxt;
        j <= j_nxt;
      end else begin
        e <= e_nxt;
      end
    end
  end

  // Addresses are registered alongside the counters they are derived from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am_src0_addr <= '0;
      am_src1_addr <= '0;
      am_dst_addr  <= '0;
      wm_addr      <= '0;
      bm_addr      <= '0;
    end else if (launch) begin
      am_src0_addr <= src0_base;
      am_src1_addr <= src1_base;
      am_dst_addr  <= dst_base;
      if (!mode) begin
        wm_addr <= wm_base;
        bm_addr <= bm_base;
      end
    end else if (adv) begin
      if (state == ST_MVMA) begin
        am_src0_addr <= src0_b + ADDR_W'(k_nxt);
        am_dst_addr  <= dst_b + ADDR_W'(j_nxt);
        bm_addr      <= bm_b + ADDR_W'(j_nxt);
        wm_addr      <= wm_addr + ADDR_W'(1);
      end else begin
        am_src0_addr <= src0_b + ADDR_W'(e_nxt);
        am_src1_addr <= src1_b + ADDR_W'(e_nxt);
        am_dst_addr  <= dst_b + ADDR_W'(e_nxt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_end_reg <= 1'b0;
    end else begin
      j_end_reg <= j_end;
    end
  end

endmodule

// File: tb/tb_rosetta_loop_sequencer.sv
// Directed bench for rosetta_loop_sequencer: per-cycle expected records are queued
// from a nested-loop reference, then popped and compared once per cycle.
module tb_rosetta_loop_sequencer;

  localparam int CNT_W  = 8;
  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              mode;
  logic [CNT_W-1:0]  k_last, i_last, j_last, e_last;
  logic [ADDR_W-1:0] src0_base, src1_base, dst_base, wm_base, bm_base;
  logic              hold;
  logic              k_end, i_end, j_end, j_end_reg, e_end, busy;
  logic [ADDR_W-1:0] am_src0_addr, am_src1_addr, am_dst_addr, wm_addr, bm_addr;

  rosetta_loop_sequencer #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mode         (mode),
    .k_last       (k_last),
    .i_last       (i_last),
    .j_last       (j_last),
    .e_last       (e_last),
    .src0_base    (src0_base),
    .src1_base    (src1_base),
    .dst_base     (dst_base),
    .wm_base      (wm_base),
    .bm_base      (bm_base),
    .hold         (hold),
    .k_end        (k_end),
    .i_end        (i_end),
    .j_end        (j_end),
    .j_end_reg    (j_end_reg),
    .e_end        (e_end),
    .am_src0_addr (am_src0_addr),
    .am_src1_addr (am_src1_addr),
    .am_dst_addr  (am_dst_addr),
    .wm_addr      (wm_addr),
    .bm_addr      (bm_addr),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags = {k_end, i_end, j_end, j_end_reg, e_end, busy}; chk = {src0, src1, dst, wm, bm}
  typedef struct {
    logic              hold;
    logic              start;
    logic [5:0]        flags;
    logic [ADDR_W-1:0] src0, src1, dst, wm, bm;
    logic [4:0]        chk;
  } rec_t;

  rec_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] obs_flags();
    return {k_end, i_end, j_end, j_end_reg, e_end, busy};
  endfunction

  task automatic push_tail(input logic was_mvma);
    rec_t r;
    r.src0 = '0; r.src1 = '0; r.dst = '0; r.wm = '0; r.bm = '0; r.chk = '0;
    r.start = 1'b0;
    r.hold  = 1'b1;   // FIN must not honour hold
    r.flags = {2'b00, was_mvma, 1'b0, 1'b0, 1'b1};
    sb.push_back(r);
    r.hold  = 1'b0;
    r.flags = {3'b000, was_mvma, 1'b0, 1'b0};
    sb.push_back(r);
    r.flags = 6'b0;
    sb.push_back(r);
  endtask

  task automatic gen_mvma(input int kl, input int il, input int jl,
                          input logic [ADDR_W-1:0] s0, input logic [ADDR_W-1:0] d,
                          input logic [ADDR_W-1:0] wb, input logic [ADDR_W-1:0] bb,
                          input int hlo, input int hhi, input int restart_cyc);
    rec_t r;
    int c;
    logic [ADDR_W-1:0] wm;
    c  = 1;
    wm = wb;
    for (int jj = 0; jj <= jl; jj++) begin
      for (int ii = 0; ii <= il; ii++) begin
        for (int kk = 0; kk <= kl; kk++) begin
          forever begin
            logic held;
            held    = (c >= hlo) && (c <= hhi);
            r.hold  = held;
            r.start = (c == restart_cyc);
            r.flags = {kk == kl, (kk == kl) && (ii == il), 1'b0, 1'b0, 1'b0, 1'b1};
            r.src0  = s0 + ADDR_W'(kk);
            r.src1  = '0;
            r.dst   = d + ADDR_W'(jj);
            r.wm    = wm;
            r.bm    = bb + ADDR_W'(jj);
            r.chk   = 5'b10111;
            sb.push_back(r);
            c++;
            if (!held) break;
          end
          wm = wm + ADDR_W'(1);
        end
      end
    end
    push_tail(1'b1);
  endtask

  task automatic gen_elem(input int el, input logic [ADDR_W-1:0] s0,
                          input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] d,
                          input int hlo, input int hhi);
    rec_t r;
    int c;
    c = 1;
    for (int ee = 0; ee <= el; ee++) begin
      forever begin
        logic held;
        held    = (c >= hlo) && (c <= hhi);
        r.hold  = held;
        r.start = 1'b0;
        r.flags = {4'b0000, ee == el, 1'b1};
        r.src0  = s0 + ADDR_W'(ee);
        r.src1  = s1 + ADDR_W'(ee);
        r.dst   = d + ADDR_W'(ee);
        r.wm    = '0;
        r.bm    = '0;
        r.chk   = 5'b11100;
        sb.push_back(r);
        c++;
        if (!held) break;
      end
    end
    push_tail(1'b0);
  endtask

  // Called just after a negedge; pulses start, then pops one record per cycle.
  task automatic run(input string name, input logic m, input int kl, input int il,
                     input int jl, input int el,
                     input logic [ADDR_W-1:0] s0, input logic [ADDR_W-1:0] s1,
                     input logic [ADDR_W-1:0] d, input logic [ADDR_W-1:0] wb,
                     input logic [ADDR_W-1:0] bb);
    rec_t r;
    int cyc;
    start = 1'b1; mode = m; hold = 1'b0;
    k_last = CNT_W'(kl); i_last = CNT_W'(il); j_last = CNT_W'(jl); e_last = CNT_W'(el);
    src0_base = s0; src1_base = s1; dst_base = d; wm_base = wb; bm_base = bb;
    cyc = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      cyc++;
      r = sb.pop_front();
      start = r.start;
      hold  = r.hold;
      if (cyc == 1) begin
        // Bounds must have been latched: disturb the inputs from here on.
        mode      = 1'($urandom_range(1));
        k_last    = CNT_W'($urandom_range(255));
        i_last    = CNT_W'($urandom_range(255));
        j_last    = CNT_W'($urandom_range(255));
        e_last    = CNT_W'($urandom_range(255));
        src0_base = ADDR_W'($urandom_range(1023));
        src1_base = ADDR_W'($urandom_range(1023));
        dst_base  = ADDR_W'($urandom_range(1023));
        bm_base   = ADDR_W'($urandom_range(1023));
      end
      check($sformatf("%s c%0d flags", name, cyc), 64'(obs_flags()), 64'(r.flags));
      if (r.chk[4]) check($sformatf("%s c%0d src0", name, cyc), 64'(am_src0_addr), 64'(r.src0));
      if (r.chk[3]) check($sformatf("%s c%0d src1", name, cyc), 64'(am_src1_addr), 64'(r.src1));
      if (r.chk[2]) check($sformatf("%s c%0d dst", name, cyc), 64'(am_dst_addr), 64'(r.dst));
      if (r.chk[1]) check($sformatf("%s c%0d wm", name, cyc), 64'(wm_addr), 64'(r.wm));
      if (r.chk[0]) check($sformatf("%s c%0d bm", name, cyc), 64'(bm_addr), 64'(r.bm));
    end
    start = 1'b0;
    hold  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; hold = 1'b0;
    k_last = '0; i_last = '0; j_last = '0; e_last = '0;
    src0_base = '0; src1_base = '0; dst_base = '0; wm_base = '0; bm_base = '0;

    #12;
    check("reset flags", 64'(obs_flags()), 64'd0);
    check("reset addrs", {14'd0, am_src0_addr, am_src1_addr, am_dst_addr, wm_addr, bm_addr}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of an MVMA loop (k=2, i=1 with k_last=3).
    start = 1'b1; mode = 1'b0; k_last = 8'd3; i_last = 8'd2; j_last = 8'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("midloop src0", 64'(am_src0_addr), 64'd2);
    check("midloop flags", 64'(obs_flags()), 64'b000001);
    #2 rst_n = 1'b0;
    #1;
    check("async rst flags", 64'(obs_flags()), 64'd0);
    check("async rst addrs", {14'd0, am_src0_addr, am_src1_addr, am_dst_addr, wm_addr, bm_addr}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check($sformatf("post rst idle %0d", n), 64'(obs_flags()), 64'd0);
    end

    gen_mvma(2, 1, 1, 10'd0, 10'd0, 10'd0, 10'd0, 0, -1, 0);
    run("mvma_basic", 1'b0, 2, 1, 1, 0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0);

    gen_mvma(2, 1, 1, 10'd0, 10'd0, 10'd0, 10'd0, 3, 5, 0);
    run("mvma_hold", 1'b0, 2, 1, 1, 0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0);

    gen_elem(4, 10'd100, 10'd200, 10'd300, 0, -1);
    run("elem", 1'b1, 0, 0, 0, 4, 10'd100, 10'd200, 10'd300, 10'd0, 10'd0);

    gen_elem(0, 10'd7, 10'd8, 10'd9, 1, 2);
    run("elem_zero_hold", 1'b1, 0, 0, 0, 0, 10'd7, 10'd8, 10'd9, 10'd0, 10'd0);

    gen_mvma(0, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0, 0, -1, 1);
    run("mvma_zero", 1'b0, 0, 0, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0);

    gen_mvma(3, 0, 1, 10'd1022, 10'd1023, 10'd1020, 10'd5, 4, 4, 0);
    run("mvma_wrap", 1'b0, 3, 0, 1, 0, 10'd1022, 10'd0, 10'd1023, 10'd1020, 10'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
